stream_match_ctrl: RTL and testbench
====================================

Name: stream_match_ctrl

Overview:
Sequencing controller for the 128-bit serial capture-and-compare path. It performs three steps:
- Shifts a framed serial bit stream (MSB first) into a 128-bit capture register and counts bits.
- On end_of_sequence, validates the frame length, then walks a bank of prestored constant keys, one per cycle.
- Reports the first matching key index with a one-cycle done pulse.

It sits between the serial receive front end and any downstream unlock/response logic.

Parameters:
DATA_W, 128, frame length in bits and width of the capture register and keys
NUM_KEYS, 4, number of prestored keys in the bank
IDX_W, 2, width of match_idx (clog2 of NUM_KEYS)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
bit_valid  input  1  bit_in is valid this cycle
bit_in  input  1  serial data bit
end_of_sequence  input  1  frame terminator, sampled only when not busy
busy  output  1  high in COMPARE and DONE; inputs ignored while high
done  output  1  one-cycle pulse: result valid
match  output  1  captured frame equals a key (valid from done onward)
match_idx  output  IDX_W  lowest matching key index; 0 when match=0
frame_err  output  1  one-cycle pulse coincident with done on a bad frame length
data_out  output  DATA_W  captured frame, held after done

Behaviour:
- Reset (async, any state): state=IDLE, shift reg=0, bit count=0, key index=0. All outputs 0.
- States: IDLE, SHIFT, COMPARE, DONE.
- Shifting, in IDLE or SHIFT with bit_valid=1: shreg <= {shreg[DATA_W-2:0], bit_in}; count increments. The first bit in IDLE moves to SHIFT with count=1.
- Frame start: the first accepted bit of a frame clears match, match_idx and data_out.
- Count width is clog2(DATA_W)+1. Count saturates at DATA_W+1, which flags overflow; it never wraps.
- end_of_sequence sampled in IDLE/SHIFT:
  - If it coincides with bit_valid, the bit is shifted first and the count check includes it.
  - count==DATA_W: go to COMPARE, key index=0, data_out <= captured value.
  - Otherwise (short, zero or overflow): go to DONE with match=0, frame_err set for the DONE cycle, no compare.
- COMPARE: one key per cycle, compared against the full DATA_W bits.
  - On equality: match=1, match_idx=index, go to DONE.
  - Index NUM_KEYS-1 without equality: match=0, go to DONE.
  - Otherwise: index+1.
- DONE: done=1 (and frame_err if flagged) for exactly one cycle. Count is cleared and the state returns to IDLE.
- Timing: with end_of_sequence sampled in cycle c:
  - A hit on key k gives done high in cycle c+2+k.
  - No hit gives done in cycle c+1+NUM_KEYS.
  - A bad length gives done in cycle c+1.
- Inputs ignored while busy: bit_valid and end_of_sequence arriving in COMPARE/DONE are dropped with no side effects.
- Idle line: bit_valid=0 and end_of_sequence=0 hold all state.
- Mid-operation reset: reset during SHIFT or COMPARE aborts immediately. No done pulse is produced and outputs return to 0.
- Output hold: match, match_idx and data_out hold until the next frame start.

Decomposition:
- Shared package stream_match_pkg holds DATA_W, NUM_KEYS, IDX_W, the state enum typedef, and the key constant array. Test keys:
  - KEY0=128'h0123456789ABCDEF_FEDCBA9876543210
  - KEY1=all ones
  - KEY2=128'hA5 repeated 16 times
  - KEY3=128'h1
- One natural sub-module: serial_shift_capture (shift register plus saturating bit counter, with shift enable, clear and count outputs). FSM and compare stay in stream_match_ctrl.

Test Plan:
- 128 bits of KEY2 then end_of_sequence → done exactly 4 cycles later (k=2), match=1, match_idx=2, frame_err=0, data_out=KEY2.
- 128 bits of 128'hDEAD…BEEF (no key) then end_of_sequence → done 5 cycles later, match=0, match_idx=0, frame_err=0.
- Edge cases:
  - 100 bits then end_of_sequence → done+frame_err next cycle, match=0.
  - 130 bits then end_of_sequence → same response.
  - end_of_sequence alone in IDLE → same response.
- 127 bits of KEY1, then the 128th bit with end_of_sequence in the same cycle → match=1, match_idx=1.
- KEY0 frame, then bit_valid toggling during COMPARE → ignored; match_idx=0. The next frame's first bit clears match and data_out.
- Reset asserted mid-SHIFT (bit 64) and mid-COMPARE → all outputs 0 immediately, no done. A following full KEY3 frame gives match_idx=3.

Source files
------------

// File: rtl/stream_match_pkg.sv
// Shared definitions for the serial capture-and-compare controller:
// sizes, FSM state encoding, the prestored key bank and small helpers.
package stream_match_pkg;

    localparam int DATA_W   = 128;
    localparam int NUM_KEYS = 4;
    localparam int IDX_W    = 2;
    // One extra bit so the counter can sit at DATA_W+1 to mark overflow.
    localparam int CNT_W    = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMPARE,
        ST_DONE
    } state_t;

    localparam logic [DATA_W-1:0] KEY0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [DATA_W-1:0] KEY1 = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] KEY2 = {16{8'hA5}};
    localparam logic [DATA_W-1:0] KEY3 = 128'h1;

    // Key bank lookup; indices beyond the bank fall back to the last key.
    function automatic logic [DATA_W-1:0] key_const(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    return KEY0;
            2'd1:    return KEY1;
            2'd2:    return KEY2;
            default: return KEY3;
        endcase
    endfunction

    // Bit counter increment that parks at DATA_W+1 instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(DATA_W + 1)) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/stream_match_ctrl_if.sv
// Stream-side bundle of the capture-and-compare controller: serial input
// framing plus the result/status outputs.
interface stream_match_ctrl_if
    import stream_match_pkg::*;
();
    logic              bit_valid;
    logic              bit_in;
    logic              end_of_sequence;
    logic              busy;
    logic              done;
    logic              match;
    logic [IDX_W-1:0]  match_idx;
    logic              frame_err;
    logic [DATA_W-1:0] data_out;

    // Front end side: drives the serial frame, observes the result.
    modport master (
        output bit_valid, bit_in, end_of_sequence,
        input  busy, done, match, match_idx, frame_err, data_out
    );

    // Controller side.
    modport slave (
        input  bit_valid, bit_in, end_of_sequence,
        output busy, done, match, match_idx, frame_err, data_out
    );
endinterface

// File: rtl/serial_shift_capture.sv
// MSB-first shift register with a saturating bit counter. The next-state
// values are exported so the controller can judge a frame whose last bit
// arrives together with the terminator.
module serial_shift_capture
    import stream_match_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              clr,
    input  logic              bit_in,
    output logic [DATA_W-1:0] shreg,
    output logic [DATA_W-1:0] shreg_next,
    output logic [CNT_W-1:0]  count_next
);
    logic [DATA_W-1:0] shreg_reg;
    logic [CNT_W-1:0]  count_reg;

    // Next shift/count value: clear wins, otherwise shift in one bit.
    always_comb begin
        shreg_next = shreg_reg;
        count_next = count_reg;
        if (clr) begin
            shreg_next = '0;
            count_next = '0;
        end else if (shift_en) begin
            shreg_next = {shreg_reg[DATA_W-2:0], bit_in};
            count_next = cnt_sat_inc(count_reg);
        end
    end

    // Capture register and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg <= '0;
            count_reg <= '0;
        end else begin
            shreg_reg <= shreg_next;
            count_reg <= count_next;
        end
    end

    assign shreg = shreg_reg;

endmodule

// File: rtl/stream_match_ctrl.sv
// Sequencing controller: captures a serial frame, checks its length, then
// walks the key bank one entry per cycle and reports the first hit.
module stream_match_ctrl
    import stream_match_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    stream_match_ctrl_if.slave  bus
);
    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  key_idx_reg, key_idx_next;
    logic              match_reg, match_next;
    logic [IDX_W-1:0]  match_idx_reg, match_idx_next;
    logic [DATA_W-1:0] data_out_reg, data_out_next;
    logic              err_reg, err_next;

    logic              accepting;
    logic              shift_en;
    logic              clr;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [CNT_W-1:0]  count_next;

    // Framing inputs are only honoured while not busy.
    assign accepting = (state_reg == ST_IDLE) || (state_reg == ST_SHIFT);
    assign shift_en  = accepting && bus.bit_valid;
    assign clr       = (state_reg == ST_DONE);

    serial_shift_capture u_capture (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (shift_en),
        .clr        (clr),
        .bit_in     (bus.bit_in),
        .shreg      (shreg),
        .shreg_next (shreg_next),
        .count_next (count_next)
    );

    // Next-state and result logic for the capture/compare sequence.
    always_comb begin
        state_next     = state_reg;
        key_idx_next   = key_idx_reg;
        match_next     = match_reg;
        match_idx_next = match_idx_reg;
        data_out_next  = data_out_reg;
        err_next       = err_reg;
        case (state_reg)
            ST_IDLE, ST_SHIFT: begin
                if (bus.bit_valid) begin
                    state_next = ST_SHIFT;
                    if (state_reg == ST_IDLE) begin
                        // First bit of a new frame drops the previous result.
                        match_next     = 1'b0;
                        match_idx_next = '0;
                        data_out_next  = '0;
                    end
                end
                if (bus.end_of_sequence) begin
                    // count_next already includes a coinciding final bit.
                    if (count_next == CNT_W'(DATA_W)) begin
                        state_next    = ST_COMPARE;
                        key_idx_next  = '0;
                        data_out_next = shreg_next;
                    end else begin
                        state_next     = ST_DONE;
                        err_next       = 1'b1;
                        match_next     = 1'b0;
                        match_idx_next = '0;
                    end
                end
            end
            ST_COMPARE: begin
                // Capture register is frozen here, so it equals data_out.
                if (shreg == key_const(key_idx_reg)) begin
                    match_next     = 1'b1;
                    match_idx_next = key_idx_reg;
                    state_next     = ST_DONE;
                end else if (key_idx_reg == IDX_W'(NUM_KEYS - 1)) begin
                    match_next     = 1'b0;
                    match_idx_next = '0;
                    state_next     = ST_DONE;
                end else begin
                    key_idx_next = key_idx_reg + IDX_W'(1);
                end
            end
            ST_DONE: begin
                err_next   = 1'b0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Controller state and held results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            key_idx_reg   <= '0;
            match_reg     <= 1'b0;
            match_idx_reg <= '0;
            data_out_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            key_idx_reg   <= key_idx_next;
            match_reg     <= match_next;
            match_idx_reg <= match_idx_next;
            data_out_reg  <= data_out_next;
            err_reg       <= err_next;
        end
    end

    assign bus.busy      = (state_reg == ST_COMPARE) || (state_reg == ST_DONE);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.frame_err = (state_reg == ST_DONE) && err_reg;
    assign bus.match     = match_reg;
    assign bus.match_idx = match_idx_reg;
    assign bus.data_out  = data_out_reg;

endmodule

// File: tb/tb_stream_match_ctrl.sv
// Directed bench for stream_match_ctrl: frames of known keys, non-keys,
// bad lengths, busy-time noise and mid-operation resets.
module tb_stream_match_ctrl;
    import stream_match_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    localparam logic [DATA_W-1:0] NOKEY = 128'hDEADBEEF_00112233_44556677_DEADBEEF;

    stream_match_ctrl_if bus ();

    stream_match_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.bit_valid       = 1'b0;
        bus.bit_in          = 1'b0;
        bus.end_of_sequence = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        idle_inputs();
    endtask

    // Shift the first nbits of val MSB first; zeros past bit 128.
    task automatic shift_bits(input logic [DATA_W-1:0] val, input int nbits, input bit eos_last);
        logic [DATA_W-1:0] v;
        v = val;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.bit_valid       = 1'b1;
            bus.bit_in          = (i < DATA_W) ? v[DATA_W-1-i] : 1'b0;
            bus.end_of_sequence = eos_last && (i == nbits - 1);
        end
    endtask

    task automatic eos_alone();
        @(negedge clk);
        bus.bit_valid       = 1'b0;
        bus.bit_in          = 1'b0;
        bus.end_of_sequence = 1'b1;
    endtask

    // Count cycles from the terminator to done, optionally poking inputs while busy.
    task automatic wait_result(input bit noise, output int lat, output logic m,
                               output logic [IDX_W-1:0] idx, output logic fe, output logic busy1);
        lat = 0; m = 1'b0; idx = '0; fe = 1'b0; busy1 = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) busy1 = bus.busy;
            if (bus.done) begin
                m   = bus.match;
                idx = bus.match_idx;
                fe  = bus.frame_err;
                if (noise) begin
                    bus.bit_valid       = 1'b1;
                    bus.bit_in          = 1'b1;
                    bus.end_of_sequence = 1'b1;
                end else begin
                    idle_inputs();
                end
                return;
            end
            if (noise) begin
                bus.bit_valid       = 1'b1;
                bus.bit_in          = lat[0];
                bus.end_of_sequence = lat[0];
            end else begin
                idle_inputs();
            end
        end
        chk("done_timeout", {127'b0, bus.done}, 128'd1);
    endtask

    task automatic expect_result(input string tag, input bit noise, input int exp_lat,
                                 input logic exp_m, input logic [IDX_W-1:0] exp_idx,
                                 input logic exp_fe, input logic [DATA_W-1:0] exp_data);
        int               lat;
        logic             m;
        logic [IDX_W-1:0] idx;
        logic             fe;
        logic             busy1;
        wait_result(noise, lat, m, idx, fe, busy1);
        chk({tag, "_latency"}, DATA_W'(lat), DATA_W'(exp_lat));
        chk({tag, "_busy"}, DATA_W'(busy1), 128'd1);
        chk({tag, "_match"}, DATA_W'(m), DATA_W'(exp_m));
        chk({tag, "_idx"}, DATA_W'(idx), DATA_W'(exp_idx));
        chk({tag, "_frame_err"}, DATA_W'(fe), DATA_W'(exp_fe));
        idle_cycle();
        chk({tag, "_done_pulse"}, DATA_W'(bus.done), 128'd0);
        chk({tag, "_err_pulse"}, DATA_W'(bus.frame_err), 128'd0);
        chk({tag, "_busy_clr"}, DATA_W'(bus.busy), 128'd0);
        chk({tag, "_data"}, bus.data_out, exp_data);
        $display("txn %s: latency=%0d match=%0d idx=%0d frame_err=%0d", tag, lat, m, idx, fe);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, DATA_W'(bus.busy), 128'd0);
        chk({tag, "_done"}, DATA_W'(bus.done), 128'd0);
        chk({tag, "_match"}, DATA_W'(bus.match), 128'd0);
        chk({tag, "_idx"}, DATA_W'(bus.match_idx), 128'd0);
        chk({tag, "_frame_err"}, DATA_W'(bus.frame_err), 128'd0);
        chk({tag, "_data"}, bus.data_out, 128'd0);
    endtask

    initial begin
        logic seen_done;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        $display("txn reset: outputs checked");
        @(negedge clk);
        rst = 1'b0;

        shift_bits(KEY2, 128, 1'b0);
        eos_alone();
        expect_result("key2", 1'b0, 4, 1'b1, 2'd2, 1'b0, KEY2);
        repeat (3) idle_cycle();
        chk("idle_hold_match", DATA_W'(bus.match), 128'd1);
        chk("idle_hold_idx", DATA_W'(bus.match_idx), 128'd2);
        chk("idle_hold_data", bus.data_out, KEY2);
        $display("txn idle_hold: results held");

        shift_bits(NOKEY, 128, 1'b0);
        eos_alone();
        expect_result("nokey", 1'b0, 5, 1'b0, 2'd0, 1'b0, NOKEY);

        shift_bits(NOKEY, 100, 1'b0);
        eos_alone();
        expect_result("short100", 1'b0, 1, 1'b0, 2'd0, 1'b1, 128'd0);

        shift_bits(KEY2, 130, 1'b0);
        eos_alone();
        expect_result("long130", 1'b0, 1, 1'b0, 2'd0, 1'b1, 128'd0);

        shift_bits(KEY1, 128, 1'b1);
        expect_result("key1_eos_last", 1'b0, 3, 1'b1, 2'd1, 1'b0, KEY1);

        eos_alone();
        expect_result("eos_only", 1'b0, 1, 1'b0, 2'd0, 1'b1, KEY1);

        shift_bits(KEY0, 128, 1'b0);
        eos_alone();
        expect_result("key0_noise", 1'b1, 2, 1'b1, 2'd0, 1'b0, KEY0);

        shift_bits(KEY3, 1, 1'b0);
        idle_cycle();
        chk("frame_start_match", DATA_W'(bus.match), 128'd0);
        chk("frame_start_idx", DATA_W'(bus.match_idx), 128'd0);
        chk("frame_start_data", bus.data_out, 128'd0);
        $display("txn frame_start: previous result cleared");

        shift_bits(KEY3, 63, 1'b0);
        idle_cycle();
        rst = 1'b1;
        #1;
        chk_all_zero("rst_shift");
        $display("txn rst_shift: reset at bit 64");
        idle_cycle();
        rst = 1'b0;

        shift_bits(KEY3, 128, 1'b0);
        eos_alone();
        idle_cycle();
        chk("compare_busy", DATA_W'(bus.busy), 128'd1);
        chk("compare_data", bus.data_out, KEY3);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_compare");
        idle_cycle();
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen_done = seen_done | bus.done;
        end
        chk("rst_compare_no_done", DATA_W'(seen_done), 128'd0);
        $display("txn rst_compare: aborted, no done");

        shift_bits(KEY3, 128, 1'b0);
        eos_alone();
        expect_result("key3", 1'b0, 5, 1'b1, 2'd3, 1'b0, KEY3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
